uart_rx_8n1: RTL and testbench

8N1 UART receiver for the iCE40UP demo transceiver. It sits directly downstream of the power-on reset generator, which drives this block's `reset` input low until the fabric has settled. Serial data from the `rx` pin is synchronised, framed and mid-bit sampled with a 3-sample majority vote. Each byte is presented on a valid/ready handshake, with framing-error and overrun reporting.

---
 rtl/uart_rx_8n1_if.sv | 10 +
 rtl/uart_rx_8n1.sv | 71 +++++++
 tb/tb_uart_rx_8n1.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// uart_rx_8n1_if: received-byte valid/ready handshake plus error pulses
interface uart_rx_8n1_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  modport master (output rx_data, rx_valid, rx_frame_err, rx_overrun, input rx_ready);
  modport slave  (input rx_data, rx_valid, rx_frame_err, rx_overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with 3-sample majority vote and valid/ready output
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic          rx_busy,
  uart_rx_8n1_if.master bus
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] S0   = CW'(H - 2);
  localparam logic [CW-1:0] S1   = CW'(H - 1);
  localparam logic [CW-1:0] MID  = CW'(H);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state, state_n;
  logic            rx_m, rx_s, rx_d;
  logic            decide, maj, stop_dec, load, overrun;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [1:0]      smp;
  // samples are taken as cnt enters H-1 and H; the third is the live rx_s on the edge cnt enters H+1
  assign decide   = cnt == MID;
  assign maj      = (smp[0] & smp[1]) | (rx_s & (smp[0] | smp[1]));
  assign stop_dec = state == STOP && decide;
  assign load     = stop_dec && maj && (!bus.rx_valid || bus.rx_ready);
  assign overrun  = stop_dec && maj && bus.rx_valid && !bus.rx_ready;
  assign rx_busy  = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = rx_d && !rx_s ? START : IDLE;
      START: state_n = !decide ? START : maj ? IDLE : DATA;
      DATA:  state_n = decide && bit_idx == 3'd7 ? STOP : DATA;
      STOP:  state_n = decide ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {rx_d, rx_s, rx_m} <= 3'b111;
      cnt                <= '0;
      smp                <= 2'b11;
      bit_idx            <= '0;
      shreg              <= '0;
      bus.rx_data        <= '0;
      bus.rx_valid       <= 1'b0;
      bus.rx_frame_err   <= 1'b0;
      bus.rx_overrun     <= 1'b0;
    end else begin
      {rx_d, rx_s, rx_m} <= {rx_s, rx_m, rx};
      cnt                <= state == IDLE || cnt == LAST ? '0 : cnt + CW'(1);
      if (cnt == S0) smp[0] <= rx_s;
      if (cnt == S1) smp[1] <= rx_s;
      if (state == START && decide) bit_idx <= '0;
      if (state == DATA && decide) begin
        shreg   <= {maj, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (load) bus.rx_data <= shreg;
      bus.rx_valid     <= load || (bus.rx_valid && !bus.rx_ready);
      bus.rx_frame_err <= stop_dec && !maj;
      bus.rx_overrun   <= overrun;
    end
  end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: directed frames against hand-computed bytes, latencies and pulse counts
module tb_uart_rx_8n1;
  localparam int CPB = 104;
  localparam int H   = CPB / 2;
  localparam int LAT = 3 + 9 * CPB + H + 1;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, ready = 1'b1, rx_busy;
  uart_rx_8n1_if bus();
  assign bus.rx_ready = ready;
  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_busy(rx_busy),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  int cyc = 0, nvr = 0, nvh = 0, nfe = 0, nov = 0, nbusy = 0;
  int vrise = 0, fe_cyc = 0, ov_cyc = 0, ts = 0;
  logic [7:0] vdata = '0;
  logic pv = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.rx_valid && !pv) begin
      vrise = cyc;
      vdata = bus.rx_data;
      nvr++;
    end
    pv = bus.rx_valid;
    if (bus.rx_valid) nvh++;
    if (bus.rx_frame_err) begin nfe++; fe_cyc = cyc; end
    if (bus.rx_overrun) begin nov++; ov_cyc = cyc; end
    if (rx_busy) nbusy++;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  // frame starts on the current cycle; gb selects a bit to invert for one cycle near mid-bit
  task automatic send(input logic [7:0] b, input logic stop, input int gb);
    logic [9:0] f;
    f  = {stop, b, 1'b0};
    ts = cyc;
    for (int i = 0; i < 10; i++)
      if (i == gb) begin
        rx = f[i];
        wait_cyc(H + 1);
        rx = ~f[i];
        wait_cyc(1);
        rx = f[i];
        wait_cyc(CPB - H - 2);
      end else begin
        rx = f[i];
        wait_cyc(CPB);
      end
  endtask
  initial begin
    int s_vr, s_vh, s_fe, s_ov, s_b, t2;
    #3 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2 rx = i[0];
    end
    #1;
    check("rst_data", bus.rx_data, 0);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_ferr", bus.rx_frame_err, 0);
    check("rst_ovr", bus.rx_overrun, 0);
    check("rst_busy", rx_busy, 0);
    rx = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    s_b = nbusy;
    wait_cyc(20);
    check("post_rst_busy", nbusy - s_b, 0);
    s_vr = nvr; s_vh = nvh; s_fe = nfe; s_ov = nov;
    send(8'hA5, 1'b1, -1);
    check("a5_latency", vrise - ts, LAT);
    check("a5_data", vdata, 8'hA5);
    check("a5_valid_cycles", nvh - s_vh, 1);
    check("a5_ferr", nfe - s_fe, 0);
    check("a5_ovr", nov - s_ov, 0);
    s_vr = nvr; s_b = nbusy;
    rx = 1'b0;
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(200);
    check("glitch_busy_cycles", nbusy - s_b, H + 1);
    check("glitch_valid", nvr - s_vr, 0);
    send(8'h5A, 1'b1, -1);
    check("after_glitch_data", vdata, 8'h5A);
    check("after_glitch_valid", nvr - s_vr, 1);
    s_vr = nvr; s_fe = nfe;
    send(8'h3C, 1'b0, -1);
    check("ferr_pulses", nfe - s_fe, 1);
    check("ferr_latency", fe_cyc - ts, LAT);
    check("ferr_valid", nvr - s_vr, 0);
    s_b = nbusy;
    wait_cyc(2000);
    check("low_line_busy", nbusy - s_b, 0);
    rx = 1'b1;
    wait_cyc(20);
    send(8'h55, 1'b1, -1);
    check("after_ferr_data", vdata, 8'h55);
    ready = 1'b0;
    s_vr = nvr; s_ov = nov;
    send(8'h11, 1'b1, -1);
    send(8'h22, 1'b1, -1);
    t2 = ts;
    check("bp_valid", bus.rx_valid, 1);
    check("bp_data", bus.rx_data, 8'h11);
    check("bp_ovr_pulses", nov - s_ov, 1);
    check("bp_ovr_latency", ov_cyc - t2, LAT);
    check("bp_valid_rises", nvr - s_vr, 1);
    wait_cyc(10);
    ready = 1'b1;
    @(posedge clk);
    #1 check("bp_accept_clear", bus.rx_valid, 0);
    #1;
    send(8'hF0, 1'b1, 4);
    check("majority_data", vdata, 8'hF0);
    wait_cyc(20);
    s_vr = nvr; s_fe = nfe;
    fork
      send(8'hE0, 1'b1, -1);
      begin
        wait_cyc(6 * CPB + 30);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("midrst_busy", rx_busy, 0);
        #1 reset = 1'b1;
      end
    join
    wait_cyc(20);
    check("midrst_valid", nvr - s_vr, 0);
    check("midrst_ferr", nfe - s_fe, 0);
    send(8'h3A, 1'b1, -1);
    check("after_midrst_data", vdata, 8'h3A);
    check("after_midrst_valid", nvr - s_vr, 1);
    wait_cyc(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
